// File: rtl/sam_pkg.sv
// rtl/sam_pkg.sv - Shared register layout, device-select codes and video mode table.
package sam_pkg;

    localparam int REG_V_LSB = 0;
    localparam int REG_F_LSB = 3;
    localparam int REG_P1    = 10;
    localparam int REG_R_LSB = 11;
    localparam int REG_M_LSB = 13;
    localparam int REG_TY    = 15;

    // FFC0-FFDF: each access sets one register bit from addr[4:1] := addr[0]
    localparam logic [10:0] REG_WIN = 11'h7FE;

    localparam logic [2:0] S_RAM  = 3'd0;
    localparam logic [2:0] S_ROM0 = 3'd1;
    localparam logic [2:0] S_ROM1 = 3'd2;
    localparam logic [2:0] S_ROM2 = 3'd3;
    localparam logic [2:0] S_IO0  = 3'd4;
    localparam logic [2:0] S_IO1  = 3'd5;
    localparam logic [2:0] S_IO2  = 3'd6;
    localparam logic [2:0] S_IO3  = 3'd7;

    // Indexed by V: element 7 first
    localparam logic [7:0][5:0] MODE_BPL = {6'd32, 6'd32, 6'd32, 6'd16,
                                            6'd32, 6'd16, 6'd16, 6'd32};
    localparam logic [7:0][3:0] MODE_REP = {4'd1, 4'd1, 4'd2, 4'd2,
                                            4'd3, 4'd3, 4'd3, 4'd12};

    function automatic logic [2:0] sam_decode(input logic [15:0] addr, input logic ty);
        logic [2:0] s;
        if (addr[15:8] != 8'hFF) begin
            if (!addr[15] || ty) begin
                s = S_RAM;
            end else begin
                case (addr[14:13])
                    2'b00:   s = S_ROM0;
                    2'b01:   s = S_ROM1;
                    default: s = S_ROM2;
                endcase
            end
        end else if (addr[7:4] == 4'hF) begin
            s = S_ROM1;
        end else begin
            case (addr[7:5])
                3'd0:    s = S_IO0;
                3'd1:    s = S_IO1;
                3'd2:    s = S_IO2;
                default: s = S_IO3;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/sam_vaddr.sv
// rtl/sam_vaddr.sv - VDG video address generator: row base, column and line-repeat counters.
module sam_vaddr
    import sam_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hs_n,
    input  logic        fs_n,
    input  logic        vdg_next,
    input  logic [2:0]  mode_v,
    input  logic [6:0]  disp_offset,
    output logic [15:0] vaddr
);

    logic        hs_q;
    logic        fs_q;
    logic        hs_fall;
    logic        fs_fall;
    logic [6:0]  f_lat;
    logic [2:0]  v_lat;
    logic [15:0] row_base;
    logic [4:0]  col;
    logic [3:0]  line_cnt;
    logic [5:0]  bpl;
    logic [3:0]  rep;

    assign hs_fall = hs_q & ~hs_n;
    assign fs_fall = fs_q & ~fs_n;
    assign bpl     = MODE_BPL[v_lat];
    assign rep     = MODE_REP[v_lat];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q     <= 1'b0;
            fs_q     <= 1'b0;
            f_lat    <= 7'd0;
            v_lat    <= 3'd0;
            row_base <= 16'd0;
            col      <= 5'd0;
            line_cnt <= 4'd0;
        end else begin
            hs_q <= hs_n;
            fs_q <= fs_n;
            if (fs_fall) begin
                row_base <= 16'd0;
                col      <= 5'd0;
                line_cnt <= 4'd0;
                f_lat    <= disp_offset;
            end else if (hs_fall) begin
                // Line just finished uses the old mode; the new V takes over from here
                col   <= 5'd0;
                v_lat <= mode_v;
                if (line_cnt + 4'd1 >= rep) begin
                    row_base <= row_base + {10'd0, bpl};
                    line_cnt <= 4'd0;
                end else begin
                    line_cnt <= line_cnt + 4'd1;
                end
            end else if (vdg_next && ({1'b0, col} != bpl - 6'd1)) begin
                col <= col + 5'd1;
            end
        end
    end

    assign vaddr = {f_lat, 9'd0} + row_base + {11'd0, col};

endmodule

// File: rtl/sam_ctrl.sv
// rtl/sam_ctrl.sv - SAM-style clock, slot and address controller; SAM_CTRL_FAST_RATE_EN enables the R fast rate.
module sam_ctrl
    import sam_pkg::*;
#(
    parameter int PHASES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        hs_n,
    input  logic        fs_n,
    input  logic        vdg_next,
    output logic        E,
    output logic        Q,
    output logic [15:0] mem_addr,
    output logic        ram_we,
    output logic [2:0]  S,
    output logic        vdg_latch,
    output logic [2:0]  mode_v,
    output logic [6:0]  disp_offset
);

    localparam logic [3:0] PH_LAST = 4'(PHASES - 1);

    logic [3:0]  ph;
    logic [3:0]  ph_next;
    logic [3:0]  ph_last;
    logic [15:0] regs;
    logic [15:0] cpu_mapped;
    logic [15:0] vaddr;
    logic        cpu_wr;
    logic        cpu_latch;
    logic        reg_wr;
    logic        fast_q;
    logic        unused_regs;

`ifdef SAM_CTRL_FAST_RATE_EN
    // Rate only changes on a cycle boundary so ph always stays even in fast mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fast_q <= 1'b0;
        end else if (ph_next == 4'd0) begin
            fast_q <= |regs[REG_R_LSB +: 2];
        end
    end
    assign unused_regs = ^regs[REG_M_LSB +: 2];
`else
    assign fast_q      = 1'b0;
    assign unused_regs = ^regs[REG_R_LSB +: 4];
`endif

    always_comb begin
        ph_last = fast_q ? 4'd14 : PH_LAST;
        if (ph == ph_last) begin
            ph_next = 4'd0;
        end else begin
            ph_next = ph + (fast_q ? 4'd2 : 4'd1);
        end
    end

    assign S = sam_decode(cpu_addr, regs[REG_TY]);

    always_comb begin
        cpu_mapped = cpu_addr;
        if (cpu_addr[15:4] == 12'hFFF) begin
            cpu_mapped[14] = 1'b0;
        end
        if ((S == S_RAM) && !regs[REG_TY]) begin
            cpu_mapped[15] = regs[REG_P1];
        end
    end

    assign reg_wr    = !cpu_rw && (cpu_addr[15:5] == REG_WIN) && (ph == ph_last);
    assign cpu_latch = (ph_next[2:0] == 3'd0) && (ph_next[3] || fast_q);

    sam_vaddr u_vaddr (
        .clk         (clk),
        .reset       (reset),
        .hs_n        (hs_n),
        .fs_n        (fs_n),
        .vdg_next    (vdg_next),
        .mode_v      (regs[REG_V_LSB +: 3]),
        .disp_offset (regs[REG_F_LSB +: 7]),
        .vaddr       (vaddr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph        <= 4'd0;
            regs      <= 16'd0;
            E         <= 1'b0;
            Q         <= 1'b0;
            mem_addr  <= 16'd0;
            cpu_wr    <= 1'b0;
            ram_we    <= 1'b0;
            vdg_latch <= 1'b0;
        end else begin
            ph        <= ph_next;
            Q         <= (ph_next >= 4'd4) && (ph_next <= 4'd11);
            E         <= ph_next[3];
            vdg_latch <= !fast_q && (ph_next == 4'd7);
            if (cpu_latch) begin
                mem_addr <= cpu_mapped;
                cpu_wr   <= !cpu_rw && (S == S_RAM);
            end else if (!fast_q && !ph_next[3]) begin
                mem_addr <= vaddr;
            end
            ram_we <= cpu_wr && (ph_next >= 4'd12) && (ph_next <= 4'd14);
            if (reg_wr) begin
                regs[cpu_addr[4:1]] <= cpu_addr[0];
            end
        end
    end

    assign mode_v      = regs[REG_V_LSB +: 3];
    assign disp_offset = regs[REG_F_LSB +: 7];

endmodule

// File: tb/tb_sam_ctrl.sv
// tb/tb_sam_ctrl.sv - Scoreboard bench for sam_ctrl: clocks, decode, video counters, reset, rate.
module tb_sam_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic        hs_n = 1'b1;
    logic        fs_n = 1'b1;
    logic        vdg_next = 1'b0;
    logic        E, Q, ram_we, vdg_latch;
    logic [15:0] mem_addr;
    logic [2:0]  S, mode_v;
    logic [6:0]  disp_offset;

    sam_ctrl #(.PHASES(16)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .hs_n(hs_n), .fs_n(fs_n), .vdg_next(vdg_next),
        .E(E), .Q(Q), .mem_addr(mem_addr), .ram_we(ram_we), .S(S),
        .vdg_latch(vdg_latch), .mode_v(mode_v), .disp_offset(disp_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  s;
        logic [6:0]  f;
        logic [2:0]  v;
    } cpu_exp_t;
    typedef struct { int off; int width; } we_exp_t;
    typedef struct { int period; int latches; } per_exp_t;

    int          total = 0;
    int          passed = 0;
    int          cnt = 0;
    logic [15:0] m_regs = 16'h0000;

    int          exp_q_rise[$];
    int          exp_e_rise[$];
    int          exp_latch_cyc[$];
    logic [15:0] exp_vid[$];
    cpu_exp_t    exp_cpu[$];
    we_exp_t     exp_we[$];
    per_exp_t    exp_per[$];
    logic [29:0] exp_rst[$];

    always @(posedge clk) begin
        if (!reset) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    initial begin : monitor
        logic q_d, e_d, l_d, w_d, have_e;
        int last_e, we_start, lat_cnt;
        cpu_exp_t c;
        we_exp_t w;
        per_exp_t p;
        q_d = 0; e_d = 0; l_d = 0; w_d = 0; have_e = 0;
        last_e = 0; we_start = 0; lat_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (exp_rst.size() > 0)
                    chk("reset_outputs", {2'b0, E, Q, ram_we, vdg_latch, mem_addr, mode_v, disp_offset},
                        {2'b0, exp_rst.pop_front()});
                have_e = 0;
            end else begin
                if (Q && !q_d && exp_q_rise.size() > 0) chk("q_rise_clk", cnt, exp_q_rise.pop_front());
                if (E && !e_d) begin
                    if (exp_e_rise.size() > 0) chk("e_rise_clk", cnt, exp_e_rise.pop_front());
                    if (have_e && exp_per.size() > 0) begin
                        p = exp_per.pop_front();
                        chk("e_period", cnt - last_e, p.period);
                        chk("latches_per_cycle", lat_cnt, p.latches);
                    end
                    if (exp_cpu.size() > 0) begin
                        c = exp_cpu.pop_front();
                        chk("cpu_s", {29'd0, S}, {29'd0, c.s});
                        chk("cpu_mem_addr", {16'd0, mem_addr}, {16'd0, c.addr});
                        chk("reg_f", {25'd0, disp_offset}, {25'd0, c.f});
                        chk("reg_v", {29'd0, mode_v}, {29'd0, c.v});
                    end
                    last_e = cnt; have_e = 1; lat_cnt = 0;
                end
                if (vdg_latch && !l_d) begin
                    lat_cnt++;
                    if (exp_latch_cyc.size() > 0) chk("latch_clk", cnt, exp_latch_cyc.pop_front());
                    if (exp_vid.size() > 0) chk("video_addr", {16'd0, mem_addr}, {16'd0, exp_vid.pop_front()});
                end
                if (ram_we && !w_d) we_start = cnt;
                if (!ram_we && w_d && exp_we.size() > 0) begin
                    w = exp_we.pop_front();
                    chk("we_offset", we_start - last_e, w.off);
                    chk("we_width", cnt - we_start, w.width);
                end
            end
            q_d = Q; e_d = E; l_d = vdg_latch; w_d = ram_we;
        end
    end

    function automatic int pending();
        return exp_q_rise.size() + exp_e_rise.size() + exp_latch_cyc.size() + exp_vid.size()
             + exp_cpu.size() + exp_we.size() + exp_per.size() + exp_rst.size();
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() != 0 && n < 200) begin @(negedge clk); n++; end
        if (pending() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d expectations pending after %0d clk, required 0", pending(), n);
            exp_q_rise.delete(); exp_e_rise.delete(); exp_latch_cyc.delete(); exp_vid.delete();
            exp_cpu.delete(); exp_we.delete(); exp_per.delete(); exp_rst.delete();
        end
    endtask

    task automatic wait_e_fall();
        int n = 0;
        while (E !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (E !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++;
            $display("FAIL e_fall_timeout: E=%b after %0d clk, required a falling edge", E, n);
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic rw, input logic [15:0] ea, input logic [2:0] es);
        cpu_exp_t c;
        wait_e_fall();
        cpu_addr = a;
        cpu_rw   = rw;
        c.addr = ea; c.s = es; c.f = m_regs[9:3]; c.v = m_regs[2:0];
        exp_cpu.push_back(c);
        wait_e_fall();
        cpu_rw = 1'b1;
        if (!rw && a[15:5] == 11'h7FE) m_regs[a[4:1]] = a[0];
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1 fs_n = 1'b0;
        repeat (2) @(posedge clk); #1 fs_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic pulse_hs();
        @(posedge clk); #1 hs_n = 1'b0;
        repeat (2) @(posedge clk); #1 hs_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : stimulus
        we_exp_t  w;
        per_exp_t p;
        int       n;

        #1 reset = 1'b0;
        exp_rst.push_back(30'd0);
        exp_rst.push_back(30'd0);
        drain();

        exp_q_rise.push_back(4);
        exp_e_rise.push_back(8);
        exp_e_rise.push_back(24);
        exp_e_rise.push_back(40);
        exp_latch_cyc.push_back(7);
        exp_latch_cyc.push_back(23);
        release_reset();
        drain();

        cpu_op(16'hA123, 1'b1, 16'hA123, 3'd2);
        cpu_op(16'hFFFE, 1'b1, 16'hBFFE, 3'd2);
        cpu_op(16'hFF22, 1'b1, 16'hFF22, 3'd5);
        cpu_op(16'h1234, 1'b1, 16'h1234, 3'd0);
        cpu_op(16'h8000, 1'b1, 16'h8000, 3'd1);
        cpu_op(16'hC000, 1'b1, 16'hC000, 3'd3);
        cpu_op(16'hFF00, 1'b1, 16'hFF00, 3'd4);
        cpu_op(16'hFF5F, 1'b1, 16'hFF5F, 3'd6);
        cpu_op(16'hFFEF, 1'b1, 16'hFFEF, 3'd7);
        cpu_op(16'hFFD5, 1'b0, 16'hFFD5, 3'd7);
        cpu_op(16'h1234, 1'b1, 16'h9234, 3'd0);
        cpu_op(16'hFFDF, 1'b0, 16'hFFDF, 3'd7);
        cpu_op(16'hC000, 1'b1, 16'hC000, 3'd0);
        cpu_op(16'h8000, 1'b1, 16'h8000, 3'd0);
        cpu_op(16'hFFDE, 1'b0, 16'hFFDE, 3'd7);
        cpu_op(16'hFFD4, 1'b0, 16'hFFD4, 3'd7);
        w.off = 4; w.width = 3;
        exp_we.push_back(w);
        cpu_op(16'h0100, 1'b0, 16'h0100, 3'd0);
        drain();

        pulse_fs();
        exp_vid.push_back(16'h0000);
        drain();
        for (int line = 1; line <= 12; line++) begin
            repeat (40) begin
                @(posedge clk); #1 vdg_next = 1'b1;
                @(posedge clk); #1 vdg_next = 1'b0;
            end
            repeat (2) @(posedge clk);
            exp_vid.push_back(16'h001F);
            drain();
            pulse_hs();
            exp_vid.push_back((line == 12) ? 16'h0020 : 16'h0000);
            drain();
        end

        cpu_op(16'hFFC7, 1'b0, 16'hFFC7, 3'd7);
        cpu_op(16'h0000, 1'b1, 16'h0000, 3'd0);
        drain();
        pulse_fs();
        exp_vid.push_back(16'h0200);
        drain();

        wait_e_fall();
        cpu_addr = 16'h0300;
        cpu_rw   = 1'b0;
        n = 0;
        while (ram_we !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (ram_we !== 1'b1) begin
            total++;
            $display("FAIL ram_we_timeout: ram_we=%b, required 1", ram_we);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) exp_rst.push_back(30'd0);
        drain();
        cpu_rw = 1'b1;
        m_regs = 16'h0000;
        exp_q_rise.push_back(4);
        exp_e_rise.push_back(8);
        release_reset();
        drain();

        cpu_op(16'hFFD7, 1'b0, 16'hFFD7, 3'd7);
        repeat (3) wait_e_fall();
`ifdef SAM_CTRL_FAST_RATE_EN
        p.period = 8;  p.latches = 0;
`else
        p.period = 16; p.latches = 1;
`endif
        exp_per.push_back(p);
        exp_per.push_back(p);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
